// File: rtl/conv_unit_sequencer.sv
// Control sequencer for a single-PE convolution unit. It accepts one window/filter pair,
// runs the unit for its fixed latency, then hands the result downstream with its output position.
module conv_unit_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned D          = 1,
  parameter int unsigned F          = 5,
  parameter int unsigned PE_LAT     = 2,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned OUT_H      = 8,
  parameter int unsigned POS_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [D*F*F*DATA_WIDTH-1:0] in_image,
  input  logic [D*F*F*DATA_WIDTH-1:0] in_filter,
  output logic                        conv_reset,
  output logic [D*F*F*DATA_WIDTH-1:0] conv_image,
  output logic [D*F*F*DATA_WIDTH-1:0] conv_filter,
  input  logic [DATA_WIDTH-1:0]       conv_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [POS_W-1:0]            out_row,
  output logic [POS_W-1:0]            out_col,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned N     = D*F*F + PE_LAT;
  localparam int unsigned CNT_W = $clog2(N+1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [POS_W-1:0]  row, col;
  logic              accept, deliver, run_done;

  assign accept   = (state == S_IDLE) && in_valid;
  assign deliver  = (state == S_HOLD) && out_ready;
  assign run_done = (state == S_RUN) && (count == CNT_W'(N-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_CLEAR;
      S_CLEAR:                state_nxt = S_RUN;
      S_RUN:   if (run_done)  state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Handshake and unit-control outputs decode straight from the state register.
  always_comb begin
    in_ready   = 1'b0;
    conv_reset = 1'b1;
    out_valid  = 1'b0;
    busy       = 1'b1;
    out_last   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_RUN:  conv_reset = 1'b0;
      S_HOLD: begin
        out_valid = 1'b1;
        out_last  = (row == POS_W'(OUT_H-1)) && (col == POS_W'(OUT_W-1));
      end
      default: ;
    endcase
  end

  // Cycle counter restarts in CLEAR so RUN always sees 0..N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                count <= '0;
    else if (state == S_CLEAR) count <= '0;
    else if (state == S_RUN)   count <= count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_image  <= '0;
      conv_filter <= '0;
    end else if (accept) begin
      conv_image  <= in_image;
      conv_filter <= in_filter;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        out_data <= '0;
    else if (run_done) out_data <= conv_result;
  end

  // Raster-order output position, advanced once per delivered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (deliver) begin
      if (col == POS_W'(OUT_W-1)) begin
        col <= '0;
        row <= (row == POS_W'(OUT_H-1)) ? '0 : row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

  assign out_row = row;
  assign out_col = col;

endmodule

// File: doc/conv_unit_sequencer.md
Name: conv_unit_sequencer

Overview:
- Control end of the convolution-unit interface: accepts one receptive-field/filter operand pair, drives the single-PE convolution unit and waits its fixed sequential latency.
- Captures the accumulated float32 result and hands it downstream on a valid/ready handshake, tagged with the output-feature-map position.
- Sits between the window/filter buffers (upstream) and the output feature-map writer (downstream).
- One instance per convolution unit.

Parameters:
- DATA_WIDTH, 32, width of one float element.
- D, 1, filter depth.
- F, 5, filter size (F x F).
- PE_LAT, 2, extra cycles the convolution unit needs beyond D*F*F (its PE clear/pipeline overhead).
- OUT_W, 8, output feature-map width in positions.
- OUT_H, 8, output feature-map height in positions.
- POS_W, 8, width of the row/col tags.

Ports:
- clk, input, 1, clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, upstream operand pair valid.
- in_ready, output, 1, sequencer can accept an operand pair.
- in_image, input, D*F*F*DATA_WIDTH, flattened receptive field; element 0 occupies the MSBs.
- in_filter, input, D*F*F*DATA_WIDTH, flattened filter; same ordering as in_image.
- conv_reset, output, 1, active-high reset to the convolution unit.
- conv_image, output, D*F*F*DATA_WIDTH, registered copy of the accepted in_image.
- conv_filter, output, D*F*F*DATA_WIDTH, registered copy of the accepted in_filter.
- conv_result, input, DATA_WIDTH, accumulated result from the convolution unit.
- out_valid, output, 1, result available.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, DATA_WIDTH, captured result.
- out_row, output, POS_W, output row of out_data.
- out_col, output, POS_W, output column of out_data.
- out_last, output, 1, out_data is position (OUT_H-1, OUT_W-1).
- busy, output, 1, high in every state except IDLE.

Behaviour:

Reset (reset=0, asynchronous):
- State IDLE; cycle count = 0; row = 0, col = 0.
- conv_reset = 1; out_valid = 0; out_data = 0; conv_image = 0; conv_filter = 0.
- in_ready = 1 once reset is released.
- Reset asserted in any state aborts the operation: no partial result is emitted and the position returns to (0,0).

States:
- IDLE: in_ready = 1, conv_reset = 1. When in_valid=1, latch in_image/in_filter into conv_image/conv_filter and go to CLEAR.
- CLEAR: exactly 1 cycle with conv_reset = 1, in_ready = 0. Then go to RUN with count = 0.
- RUN: conv_reset = 0; count increments each cycle. When count = N-1, where N = D*F*F+PE_LAT, register conv_result into out_data at that edge and go to HOLD.
- HOLD: conv_reset = 1, out_valid = 1. out_data, out_row, out_col and out_last are stable while out_ready = 0. When out_ready=1, go to IDLE, clear out_valid and advance the position.

Latency and throughput:
- Accept edge to out_valid rising edge = N+1 cycles. Defaults: 28 cycles.
- With out_ready tied high, one result every N+3 cycles.

Handshakes:
- Transfers happen only when valid and ready are both high.
- in_ready is 0 outside IDLE, so in_valid in any other state is not accepted, and conv_image/conv_filter stay unchanged.
- out_valid never drops without out_ready.

Position counter:
- Advances on each output handshake: col+1. When col = OUT_W-1: col = 0, row+1. When additionally row = OUT_H-1: wrap to (0,0).
- out_row/out_col show the position of the result currently held.
- out_last = (row == OUT_H-1) && (col == OUT_W-1) while out_valid is high; 0 otherwise.

Width rules:
- Count width is clog2(N+1).
- conv_result is captured unmodified; no arithmetic is done in this block.

Test Plan:
1. Single window, defaults, convolution-unit model returns 32'h40A00000 at count 26 -> in_ready falls next cycle; conv_reset low for exactly 27 cycles; out_valid rises 28 cycles after the accept edge; out_data=32'h40A00000, row=0, col=0, out_last=0.
2. Backpressure: out_ready held low 10 cycles after out_valid -> out_data/out_row/out_col constant, in_ready=0, in_valid pulses ignored (conv_image unchanged); with out_ready=1, IDLE in the next cycle.
3. Back-to-back with out_ready=1, in_valid=1 continuously, 4 windows -> results 30 cycles apart, cols 0,1,2,3, no window dropped or duplicated.
4. OUT_W=3, OUT_H=2, 7 windows -> tags (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(0,0); out_last high only on the 6th.
5. reset driven low at RUN count 10 -> immediately conv_reset=1, out_valid=0, busy=0. After release: in_ready=1, next result tagged (0,0), full 28-cycle latency.
6. D=2, F=3, PE_LAT=2 -> N=20; out_valid 21 cycles after accept; conv_image equals in_image captured at the accept edge.
